// File: rtl/reg_file_master_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_master_if
// Description : Request/response command channel for reg_file_master.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_master_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;
  logic              rsp_err;

  // The command engine receives requests and produces responses.
  modport slave (
    input  req_valid, req_op, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );

  modport master (
    output req_valid, req_op, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_master.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_master
// Description : Command initiator for the 8-bit general-purpose register file.
//               READ/WRITE/INCF/DECF with read-modify-write for INCF/DECF.
//               Optional macro RFM_VERIFY_EN adds a read-back verify cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_master #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int ADDR_LO = 8
) (
  input  wire logic              clock,
  input  wire logic              reset,
  reg_file_master_if.slave       bus,
  output logic [ADDR_W-1:0]      rf_address,
  output logic                   rf_write_en,
  output logic                   rf_out_en,
  output logic [DATA_W-1:0]      rf_data_in,
  input  wire logic [DATA_W-1:0] rf_data_out
);

  localparam logic [1:0] c_OP_READ  = 2'b00;
  localparam logic [1:0] c_OP_WRITE = 2'b01;
  localparam logic [1:0] c_OP_DECF  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_VF   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_op, w_op_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic [DATA_W-1:0] r_rsp_data, w_rsp_data_nxt;
  logic              r_rsp_zero, w_rsp_zero_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic              r_req_ready, w_req_ready_nxt;
  logic [ADDR_W-1:0] r_rf_address, w_rf_address_nxt;
  logic [DATA_W-1:0] r_rf_data_in, w_rf_data_in_nxt;
  logic              r_rf_we, w_rf_we_nxt;
  logic              r_rf_oe, w_rf_oe_nxt;
  logic [DATA_W-1:0] w_rd_mod;

  // All outputs are registered from next-state values, so async reset clears them at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rsp_data   <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_req_ready  <= 1'b0;
      r_rf_address <= '0;
      r_rf_data_in <= '0;
      r_rf_we      <= 1'b0;
      r_rf_oe      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_op         <= w_op_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_rsp_data   <= w_rsp_data_nxt;
      r_rsp_zero   <= w_rsp_zero_nxt;
      r_rsp_err    <= w_rsp_err_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_rf_address <= w_rf_address_nxt;
      r_rf_data_in <= w_rf_data_in_nxt;
      r_rf_we      <= w_rf_we_nxt;
      r_rf_oe      <= w_rf_oe_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_op_nxt         = r_op;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_rsp_data_nxt   = r_rsp_data;
    w_rsp_zero_nxt   = r_rsp_zero;
    w_rsp_err_nxt    = r_rsp_err;
    w_rsp_valid_nxt  = 1'b0;
    w_req_ready_nxt  = 1'b0;
    w_rf_address_nxt = r_rf_address;
    w_rf_data_in_nxt = r_rf_data_in;
    w_rf_we_nxt      = 1'b0;
    w_rf_oe_nxt      = 1'b0;
    w_rd_mod = (r_op == c_OP_DECF) ? rf_data_out - DATA_W'(1) : rf_data_out + DATA_W'(1);

    case (r_state)
      S_IDLE: begin
        if (bus.req_valid && r_req_ready) begin
          w_op_nxt   = bus.req_op;
          w_addr_nxt = bus.req_addr;
          if (bus.req_addr < ADDR_W'(ADDR_LO)) begin
            w_state_nxt     = S_RESP;
            w_rsp_data_nxt  = '0;
            w_rsp_zero_nxt  = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_valid_nxt = 1'b1;
          end else if (bus.req_op == c_OP_WRITE) begin
            w_state_nxt      = S_WR;
            w_wdata_nxt      = bus.req_data;
            w_rf_we_nxt      = 1'b1;
            w_rf_address_nxt = bus.req_addr;
            w_rf_data_in_nxt = bus.req_data;
          end else begin
            w_state_nxt      = S_RD;
            w_rf_oe_nxt      = 1'b1;
            w_rf_address_nxt = bus.req_addr;
          end
        end else begin
          w_req_ready_nxt = 1'b1;
        end
      end
      S_RD: begin
        if (r_op == c_OP_READ) begin
          w_state_nxt     = S_RESP;
          w_rsp_data_nxt  = rf_data_out;
          w_rsp_zero_nxt  = (rf_data_out == '0);
          w_rsp_err_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
        end else begin
          w_state_nxt      = S_WR;
          w_wdata_nxt      = w_rd_mod;
          w_rf_we_nxt      = 1'b1;
          w_rf_data_in_nxt = w_rd_mod;
        end
      end
      S_WR: begin
`ifdef RFM_VERIFY_EN
        w_state_nxt = S_VF;
        w_rf_oe_nxt = 1'b1;
`else
        w_state_nxt     = S_RESP;
        w_rsp_data_nxt  = r_wdata;
        w_rsp_zero_nxt  = (r_wdata == '0);
        w_rsp_err_nxt   = 1'b0;
        w_rsp_valid_nxt = 1'b1;
`endif
      end
`ifdef RFM_VERIFY_EN
      S_VF: begin
        // Report the intended value even when the read-back disagrees.
        w_state_nxt     = S_RESP;
        w_rsp_data_nxt  = r_wdata;
        w_rsp_zero_nxt  = (r_wdata == '0);
        w_rsp_err_nxt   = (rf_data_out != r_wdata);
        w_rsp_valid_nxt = 1'b1;
      end
`endif
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt     = S_IDLE;
          w_req_ready_nxt = 1'b1;
        end else begin
          w_rsp_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_zero  = r_rsp_zero;
  assign bus.rsp_err   = r_rsp_err;
  assign rf_address    = r_rf_address;
  assign rf_write_en   = r_rf_we;
  assign rf_out_en     = r_rf_oe;
  assign rf_data_in    = r_rf_data_in;

endmodule
`default_nettype wire
